// File: rtl/imem_loader.sv
// imem_loader: downloads a length-prefixed byte stream into imem while holding the core in reset.
// Optional checksum byte after the data words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int capacity = 128,
    parameter int WIDTH = 32,
    localparam int addr_width = $clog2(capacity)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  we,
    output logic [addr_width-1:0] waddr,
    output logic [WIDTH-1:0]      wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int nbytes = WIDTH / 8;
    localparam int bw = $clog2(nbytes + 1);
    localparam logic [bw-1:0] last = bw'(nbytes - 1);
    localparam logic [16:0] cap = 17'(capacity);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, WRITE, FIN
`ifdef IMEM_LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t after_data = CHK;
    logic [7:0] chk;
`else
    localparam state_t after_data = FIN;
`endif

    state_t state, nxt;
    logic [7:0] len_hi;
    logic [15:0] len, idx;
    logic [WIDTH-1:0] word;
    logic [bw-1:0] bcnt;
    logic err_q, ovf;

    assign ovf = {1'b0, idx} >= cap;
    assign we = state == WRITE && !ovf;
    assign waddr = idx[addr_width-1:0];
    assign wdata = word;
    assign busy = state != IDLE;
    assign cpu_rst = busy;
    assign done = state == FIN;
    assign err = err_q;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end

    // next state and byte-acceptance
    always_comb begin
        nxt = state;
        rx_ready = 1'b0;
        case (state)
            IDLE: nxt = load_req ? LEN_HI : IDLE;
            LEN_HI: begin
                rx_ready = 1'b1;
                nxt = rx_valid ? LEN_LO : LEN_HI;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) nxt = ({len_hi, rx_data} == 16'd0) ? after_data : DATA;
            end
            DATA: begin
                rx_ready = 1'b1;
                nxt = (rx_valid && bcnt == last) ? WRITE : DATA;
            end
            WRITE: nxt = (idx + 16'd1 == len) ? after_data : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                rx_ready = 1'b1;
                nxt = rx_valid ? FIN : CHK;
            end
`endif
            FIN: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // length capture, word assembly, word index and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi <= '0;
            len <= '0;
            idx <= '0;
            word <= '0;
            bcnt <= '0;
            err_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk <= '0;
`endif
        end else begin
            if (state == IDLE && load_req) begin
                idx <= '0;
                err_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk <= '0;
`endif
            end
            if (state == LEN_HI && rx_valid) len_hi <= rx_data;
            if (state == LEN_LO && rx_valid) begin
                len <= {len_hi, rx_data};
                bcnt <= '0;
            end
            if (state == DATA && rx_valid) begin
                word <= WIDTH'({word, rx_data});
                bcnt <= (bcnt == last) ? '0 : bcnt + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk <= chk ^ rx_data;
`endif
            end
            if (state == WRITE) begin
                idx <= idx + 16'd1;
                if (ovf) err_q <= 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (state == CHK && rx_valid && rx_data != chk) err_q <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized downloads checked against a word-list model.
module tb_imem_loader;
    localparam int CAP = 128;

    logic clk = 1'b0;
    logic reset, load_req, rx_valid;
    logic [7:0] rx_data;
    logic rx_ready, we, cpu_rst, busy, done, err;
    logic [6:0] waddr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    imem_loader #(.capacity(CAP), .WIDTH(32)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ready(rx_ready), .we(we), .waddr(waddr),
        .wdata(wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    int total = 0;
    int bad = 0;
    logic [38:0] wq[$];
    logic [31:0] words[$];
    int dones;
    logic rst_at_done;

    // record every imem write and done pulse just after each edge
    always @(posedge clk) begin
        #1;
        if (we) wq.push_back({waddr, wdata});
        if (done) begin
            dones++;
            rst_at_done = cpu_rst;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            rx_data = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last_of_word, input bit exp_we);
        int t = 0;
        rx_valid = 1'b1;
        rx_data = b;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_timeout", 64'(t < 50), 1);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
        if (last_of_word) begin
            chk("we_latency", we, exp_we);
            chk("ready_in_write", rx_ready, 0);
        end
    endtask

    task automatic run_load(input int n, input int gap, input bit gap5, input bit bad_sum);
        int t = 0;
        int nw;
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        bit exp_err;
        dones = 0;
        wq.delete();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("start_flags", {busy, cpu_rst, err}, 3'b110);
        send_byte(n[15:8], 0, 0);
        send_byte(n[7:0], 0, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (n == 0) chk("done_after_len", done, 1);
`endif
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (gap > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, gap));
                if (gap5 && j == 2) idle(5);
                if (i == 0 && j == 2) begin
                    load_req = 1'b1;
                    @(negedge clk);
                    load_req = 1'b0;
                end
                b = words[i][31-8*j -: 8];
                x ^= b;
                send_byte(b, j == 3, i < CAP);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_sum ? x ^ 8'h01 : x, 0, 0);
        exp_err = (n > CAP) || bad_sum;
`else
        exp_err = n > CAP;
`endif
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("end_busy", busy, 0);
        chk("end_cpu_rst", cpu_rst, 0);
        chk("done_count", dones, 1);
        chk("cpu_rst_at_done", rst_at_done, 1);
        chk("err", err, exp_err);
        nw = (n < CAP) ? n : CAP;
        chk("write_count", wq.size(), nw);
        for (int k = 0; k < nw && k < wq.size(); k++)
            chk("write", wq[k], {k[6:0], words[k]});
    endtask

    initial begin
        int n;
        logic [31:0] w0;
        reset = 1'b1;
        load_req = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_outs", {rx_ready, we, waddr, wdata, cpu_rst, busy, done, err}, 0);
        reset = 1'b0;
        @(negedge clk);

        words = '{32'h20080005, 32'hAC080004};
        run_load(2, 0, 0, 0);
        run_load(0, 0, 0, 0);

        words.delete();
        for (int i = 0; i < 130; i++) words.push_back(32'h11111111);
        run_load(130, 0, 0, 0);

        words = '{32'h20080005, 32'hAC080004};
        run_load(2, 0, 1, 0);

        words.delete();
        for (int i = 0; i < 3; i++) words.push_back($urandom);
        w0 = words[0];
        wq.delete();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        send_byte(8'h00, 0, 0);
        send_byte(8'h03, 0, 0);
        for (int j = 0; j < 4; j++) send_byte(w0[31-8*j -: 8], j == 3, 1);
        send_byte(words[1][31:24], 0, 0);
        send_byte(words[1][23:16], 0, 0);
        reset = 1'b1;
        load_req = 1'b1;
        @(negedge clk);
        chk("abort_outs", {cpu_rst, busy, rx_ready, we, done, err}, 0);
        reset = 1'b0;
        load_req = 1'b0;
        @(negedge clk);
        chk("abort_writes", wq.size(), 1);
        if (wq.size() > 0) chk("abort_word0", wq[0], {7'd0, w0});
        run_load(3, 2, 0, 0);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 10);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            run_load(n, 3, 0, 0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        words = '{32'h01020304};
        run_load(1, 0, 0, 0);
        run_load(1, 0, 0, 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
